// File: rtl/sha_req_arbiter_pkg.sv
// Shared definitions for the SHA-256 request arbiter and the SHA-256 core:
// FSM state encoding, block/hash widths and the SHA-256 constants.
package sha_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_HASH = 2'd2,
      ST_RESPOND   = 2'd3
   } sha_state_e;

   localparam int BLOCK_W = 512;
   localparam int HASH_W  = 256;

   localparam logic [31:0] SHA_H_INIT [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] SHA_K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

endpackage

// File: rtl/sha_req_arbiter_if.sv
// Bundle of requester, response and core-side signals of the SHA request arbiter.
// master = arbiter side, slave = requesters/consumer/core side.
interface sha_req_arbiter_if
   import sha_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ*BLOCK_W-1:0] req_message_p;
   logic [NUM_REQ-1:0]         req_valid_p;
   logic [NUM_REQ-1:0]         req_ready_p;
   logic [HASH_W-1:0]          rsp_hash_p;
   logic [ID_W-1:0]            rsp_id_p;
   logic                       rsp_error_p;
   logic                       rsp_valid_p;
   logic                       rsp_ready_p;
   logic [BLOCK_W-1:0]         core_message_p;
   logic                       core_message_valid_p;
   logic                       core_message_ready_p;
   logic [HASH_W-1:0]          core_hash_p;
   logic                       core_hash_valid_p;
   logic                       core_hash_ready_p;
   logic                       busy_p;

   modport master (
      input  req_message_p, req_valid_p, rsp_ready_p,
             core_message_ready_p, core_hash_p, core_hash_valid_p,
      output req_ready_p, rsp_hash_p, rsp_id_p, rsp_error_p, rsp_valid_p,
             core_message_p, core_message_valid_p, core_hash_ready_p, busy_p
   );

   modport slave (
      output req_message_p, req_valid_p, rsp_ready_p,
             core_message_ready_p, core_hash_p, core_hash_valid_p,
      input  req_ready_p, rsp_hash_p, rsp_id_p, rsp_error_p, rsp_valid_p,
             core_message_p, core_message_valid_p, core_hash_ready_p, busy_p
   );
endinterface

// File: rtl/sha_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last+1 with wrap
// and returns a one-hot grant plus the winning index.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_any
);
   localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   always_comb begin
      int               cand;
      logic [SEL_W-1:0] sel;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = 0;
      sel       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(last) + k) % NUM_REQ;
         sel  = SEL_W'(cand);
         if (!grant_any && req[sel]) begin
            grant_any  = 1'b1;
            grant[sel] = 1'b1;
            grant_idx  = ID_W'(sel);
         end
      end
   end
endmodule

// File: rtl/sha_req_arbiter.sv
// Shares one SHA-256 core between NUM_REQ requesters: round-robin grant,
// one job in flight, watchdog-protected hash capture, ID-tagged response.
module sha_req_arbiter
   import sha_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                clk_p,
   input logic                reset_n_p,
   sha_req_arbiter_if.master  bus
);
   localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES);

   sha_state_e          state_q, state_d;
   logic [ID_W-1:0]     ptr_q, id_q;
   logic [BLOCK_W-1:0]  msg_q, sel_msg;
   logic [HASH_W-1:0]   hash_q;
   logic                err_q;
   logic [WD_W-1:0]     wdog_q;
   logic                wdog_expire;
   logic [NUM_REQ-1:0]  grant, req_ready;
   logic [ID_W-1:0]     grant_idx;
   logic                grant_any, core_start, rsp_valid;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
      .req       (bus.req_valid_p),
      .last      (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   always_comb begin
      sel_msg = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (grant[r]) sel_msg = bus.req_message_p[r*BLOCK_W +: BLOCK_W];
      end
   end

   // The counter value seen here is one behind; expiring on LAST means the
   // error response appears TIMEOUT_CYCLES+1 cycles after the core start.
   assign wdog_expire = (wdog_q >= WD_LAST);

   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      core_start = 1'b0;
      rsp_valid  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (grant_any && reset_n_p) begin
               req_ready = grant;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            core_start = bus.core_message_ready_p;
            if (bus.core_message_ready_p) state_d = ST_WAIT_HASH;
         end
         ST_WAIT_HASH: begin
            if (bus.core_hash_valid_p || wdog_expire) state_d = ST_RESPOND;
         end
         ST_RESPOND: begin
            rsp_valid = 1'b1;
            if (bus.rsp_ready_p) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_p or negedge reset_n_p) begin
      if (!reset_n_p) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   always_ff @(posedge clk_p or negedge reset_n_p) begin
      if (!reset_n_p) begin
         ptr_q  <= ID_W'(NUM_REQ - 1);
         id_q   <= '0;
         msg_q  <= '0;
         hash_q <= '0;
         err_q  <= 1'b0;
         wdog_q <= '0;
      end else begin
         if (state_q == ST_IDLE && grant_any) begin
            msg_q <= sel_msg;
            id_q  <= grant_idx;
            ptr_q <= grant_idx;
         end
         if (state_q == ST_ISSUE) wdog_q <= '0;
         if (state_q == ST_WAIT_HASH) begin
            if (wdog_q != WD_MAX) wdog_q <= wdog_q + 1'b1;
            // A hash arriving on the expiry cycle still wins.
            if (bus.core_hash_valid_p) begin
               hash_q <= bus.core_hash_p;
               err_q  <= 1'b0;
            end else if (wdog_expire) begin
               hash_q <= '0;
               err_q  <= 1'b1;
            end
         end
      end
   end

   assign bus.req_ready_p          = req_ready;
   assign bus.core_message_p       = msg_q;
   assign bus.core_message_valid_p = core_start;
   assign bus.core_hash_ready_p    = 1'b1;
   assign bus.rsp_hash_p           = hash_q;
   assign bus.rsp_id_p             = id_q;
   assign bus.rsp_error_p          = err_q;
   assign bus.rsp_valid_p          = rsp_valid;
   assign bus.busy_p               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha_req_arbiter.sv
// Scoreboard bench for sha_req_arbiter with a behavioural SHA-256 core model
// and a round-robin reference computed from the requester valid vector.
module tb_sha_req_arbiter;
   import sha_pkg::*;

   localparam int NR = 4;
   localparam int TO = 100;
   localparam logic [255:0] ABC_HASH =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

   typedef struct {
      int           id;
      logic [255:0] hash;
      logic         err;
   } exp_t;

   logic clk_p = 1'b0;
   logic reset_n_p = 1'b0;
   always #5 clk_p = ~clk_p;

   sha_req_arbiter_if #(.NUM_REQ(NR), .ID_W(2)) bus ();

   sha_req_arbiter #(.NUM_REQ(NR), .ID_W(2), .TIMEOUT_CYCLES(TO)) dut (
      .clk_p     (clk_p),
      .reset_n_p (reset_n_p),
      .bus       (bus)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   exp_t sb[$];
   logic [511:0] job_q [NR][$];
   int id_log[$];
   logic [NR-1:0] hs_vec = '0;
   logic start_flag = 1'b0;
   logic [511:0] start_msg = '0;
   int start_cyc = 0, rise_cyc = 0;
   int grants = 0, starts = 0, rsp_cnt = 0, model_last = NR - 1;
   logic rand_mode = 1'b0, core_drop = 1'b0, rsp_ready_cmd = 1'b1;
   int core_fix_delay = 0, inject_req = 0, inject_ack = 0;
   logic [255:0] last_hash = '0;
   int last_id = -1;
   logic last_err = 1'b0;
   logic prev_rv = 1'b0, prev_rr = 1'b0, prev_err = 1'b0;
   logic [255:0] prev_hash = '0;
   logic [1:0] prev_id = '0;

   always @(posedge clk_p) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha256_blk(input logic [511:0] blk);
      logic [31:0] w[64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk[i*32 +: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      a = SHA_H_INIT[0]; b = SHA_H_INIT[1]; c = SHA_H_INIT[2]; d = SHA_H_INIT[3];
      e = SHA_H_INIT[4]; f = SHA_H_INIT[5]; g = SHA_H_INIT[6]; h = SHA_H_INIT[7];
      for (int i = 0; i < 64; i++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {a + SHA_H_INIT[0], b + SHA_H_INIT[1], c + SHA_H_INIT[2], d + SHA_H_INIT[3],
              e + SHA_H_INIT[4], f + SHA_H_INIT[5], g + SHA_H_INIT[6], h + SHA_H_INIT[7]};
   endfunction

   function automatic int rr_pick(input logic [NR-1:0] v, input int last);
      for (int k = 1; k <= NR; k++) begin
         int c;
         c = (last + k) % NR;
         if (((v >> c) & 1) != 0) return c;
      end
      return -1;
   endfunction

   function automatic logic [511:0] rand_blk();
      logic [511:0] m;
      for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom;
      return m;
   endfunction

   // Requester and response-consumer driver
   initial begin
      logic [NR-1:0] v;
      logic [NR*512-1:0] m;
      bus.req_valid_p = '0;
      bus.req_message_p = '0;
      bus.rsp_ready_p = 1'b1;
      forever begin
         @(posedge clk_p);
         #1;
         v = '0;
         m = '0;
         for (int r = 0; r < NR; r++) begin
            if (hs_vec[r] && job_q[r].size() > 0) void'(job_q[r].pop_front());
            if (job_q[r].size() > 0) begin
               m = m | ((NR*512)'(job_q[r][0]) << (r*512));
               if (!rand_mode || ($urandom % 8) != 0) v = v | (NR'(1) << r);
            end
         end
         bus.req_valid_p = v;
         bus.req_message_p = m;
         bus.rsp_ready_p = rand_mode ? (($urandom % 3) != 0) : rsp_ready_cmd;
      end
   end

   // Behavioural SHA-256 core
   initial begin
      int cnt;
      logic [511:0] cmsg;
      cnt = 0;
      cmsg = '0;
      bus.core_message_ready_p = 1'b1;
      bus.core_hash_p = '0;
      bus.core_hash_valid_p = 1'b0;
      forever begin
         @(posedge clk_p);
         #1;
         bus.core_hash_valid_p = 1'b0;
         if (!reset_n_p) begin
            cnt = 0;
         end else begin
            if (inject_ack != inject_req) begin
               bus.core_hash_p = {8{$urandom}};
               bus.core_hash_valid_p = 1'b1;
               inject_ack = inject_req;
            end
            if (start_flag) begin
               if (!core_drop) cnt = (core_fix_delay > 0) ? core_fix_delay : int'($urandom_range(1, 40));
               cmsg = start_msg;
            end else if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  bus.core_hash_p = sha256_blk(cmsg);
                  bus.core_hash_valid_p = 1'b1;
               end
            end
         end
         bus.core_message_ready_p = rand_mode ? (($urandom % 4) != 0) : 1'b1;
      end
   end

   // Monitor: grant reference, scoreboard push/pop, stability checks
   always @(negedge clk_p) begin
      if (!reset_n_p) begin
         hs_vec = '0;
         start_flag = 1'b0;
         prev_rv = 1'b0;
      end else begin
         hs_vec = bus.req_valid_p & bus.req_ready_p;
         if (bus.req_ready_p != '0) begin
            chk("ready_onehot", 256'($onehot(bus.req_ready_p)), 256'(1));
            chk("ready_only_idle", 256'(bus.busy_p), 256'(0));
         end
         if (hs_vec != '0) begin
            int w;
            logic [511:0] blk;
            w = rr_pick(bus.req_valid_p, model_last);
            chk("grant", 256'(bus.req_ready_p), 256'(NR'(1) << w));
            blk = 512'(bus.req_message_p >> (w*512));
            sb.push_back('{id: w, hash: core_drop ? 256'(0) : sha256_blk(blk), err: core_drop});
            model_last = w;
            grants++;
         end
         start_flag = bus.core_message_valid_p & bus.core_message_ready_p;
         if (start_flag) begin
            starts++;
            start_msg = bus.core_message_p;
            start_cyc = cyc;
         end
         if (bus.rsp_valid_p && !prev_rv) rise_cyc = cyc;
         if (prev_rv && !prev_rr) begin
            chk("rsp_held_valid", 256'(bus.rsp_valid_p), 256'(1));
            chk("rsp_held_hash", bus.rsp_hash_p, prev_hash);
            chk("rsp_held_id", 256'(bus.rsp_id_p), 256'(prev_id));
            chk("rsp_held_err", 256'(bus.rsp_error_p), 256'(prev_err));
         end
         if (bus.rsp_valid_p && bus.rsp_ready_p) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rsp: got id %0d with nothing expected", bus.rsp_id_p);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_id", 256'(bus.rsp_id_p), 256'(e.id));
               chk("rsp_hash", bus.rsp_hash_p, e.hash);
               chk("rsp_err", 256'(bus.rsp_error_p), 256'(e.err));
            end
            rsp_cnt++;
            last_hash = bus.rsp_hash_p;
            last_id = int'(bus.rsp_id_p);
            last_err = bus.rsp_error_p;
            id_log.push_back(int'(bus.rsp_id_p));
         end
         prev_rv = bus.rsp_valid_p;
         prev_rr = bus.rsp_ready_p;
         prev_hash = bus.rsp_hash_p;
         prev_id = bus.rsp_id_p;
         prev_err = bus.rsp_error_p;
      end
   end

   function automatic bit all_idle();
      for (int r = 0; r < NR; r++) if (job_q[r].size() > 0) return 1'b0;
      return (sb.size() == 0) && !bus.busy_p && !bus.rsp_valid_p;
   endfunction

   task automatic wait_idle(input int budget, input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk_p);
         n++;
      end while (!all_idle() && n < budget);
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL %s: not idle after %0d cycles, expected idle", nm, budget);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_busy"}, 256'(bus.busy_p), 256'(0));
      chk({nm, "_rsp_valid"}, 256'(bus.rsp_valid_p), 256'(0));
      chk({nm, "_core_valid"}, 256'(bus.core_message_valid_p), 256'(0));
      chk({nm, "_req_ready"}, 256'(bus.req_ready_p), 256'(0));
      chk({nm, "_rsp_hash"}, bus.rsp_hash_p, 256'(0));
      chk({nm, "_rsp_id"}, 256'(bus.rsp_id_p), 256'(0));
      chk({nm, "_rsp_err"}, 256'(bus.rsp_error_p), 256'(0));
      chk({nm, "_core_msg"}, 256'(bus.core_message_p != '0), 256'(0));
      chk({nm, "_core_hash_ready"}, 256'(bus.core_hash_ready_p), 256'(1));
   endtask

   initial begin
      logic [511:0] abc;
      int n, s;
      for (int r = 0; r < NR; r++) job_q[r].push_back(rand_blk());
      repeat (3) @(posedge clk_p);
      #2;
      chk_all_zero("reset");
      @(negedge clk_p);
      reset_n_p = 1'b1;

      // All four valid from reset: strict rotation 0,1,2,3
      wait_idle(3000, "contention");
      for (int i = 0; i < NR; i++) chk("contention_order", 256'(id_log.size() > i ? id_log[i] : -1), 256'(i));

      abc = '0;
      abc[31:0] = 32'h61626380;
      abc[15*32 +: 32] = 32'h00000018;
      job_q[0].push_back(abc);
      wait_idle(500, "abc");
      chk("abc_hash", last_hash, ABC_HASH);
      chk("abc_id", 256'(last_id), 256'(0));

      rand_mode = 1'b1;
      for (int r = 0; r < NR; r++) begin
         n = $urandom_range(2, 5);
         for (int j = 0; j < n; j++) job_q[r].push_back(rand_blk());
      end
      wait_idle(20000, "random");
      rand_mode = 1'b0;
      repeat (2) @(negedge clk_p);

      // Response back-pressure with a competing request pending
      rsp_ready_cmd = 1'b0;
      n = rsp_cnt;
      job_q[1].push_back(rand_blk());
      s = 0;
      do begin
         @(negedge clk_p);
         s++;
      end while (!bus.rsp_valid_p && s < 300);
      chk("bp_rsp_seen", 256'(bus.rsp_valid_p), 256'(1));
      job_q[3].push_back(rand_blk());
      repeat (20) begin
         @(negedge clk_p);
         chk("bp_no_ready", 256'(bus.req_ready_p), 256'(0));
         chk("bp_valid_held", 256'(bus.rsp_valid_p), 256'(1));
      end
      chk("bp_no_rsp_yet", 256'(rsp_cnt), 256'(n));
      rsp_ready_cmd = 1'b1;
      wait_idle(500, "bp_release");
      chk("bp_rsp_count", 256'(rsp_cnt), 256'(n + 2));

      // Lost hash: watchdog error response
      core_drop = 1'b1;
      job_q[0].push_back(rand_blk());
      wait_idle(1000, "timeout");
      core_drop = 1'b0;
      chk("timeout_latency", 256'(rise_cyc - start_cyc), 256'(TO + 1));
      chk("timeout_err", 256'(last_err), 256'(1));
      chk("timeout_hash", last_hash, 256'(0));

      // Late hash pulse while idle must not create a response
      n = rsp_cnt;
      inject_req++;
      repeat (10) @(negedge clk_p);
      chk("late_hash_no_rsp", 256'(rsp_cnt), 256'(n));
      chk("late_hash_idle", 256'(bus.busy_p), 256'(0));

      // Reset while waiting for the hash
      core_fix_delay = 60;
      s = starts;
      job_q[1].push_back(rand_blk());
      n = 0;
      do begin
         @(negedge clk_p);
         n++;
      end while (starts == s && n < 300);
      chk("midreset_started", 256'(starts), 256'(s + 1));
      repeat (5) @(negedge clk_p);
      #2;
      reset_n_p = 1'b0;
      #1;
      chk_all_zero("midreset");
      sb.delete();
      model_last = NR - 1;
      repeat (3) @(posedge clk_p);
      @(negedge clk_p);
      reset_n_p = 1'b1;
      core_fix_delay = 0;
      n = rsp_cnt;
      job_q[2].push_back(rand_blk());
      wait_idle(500, "after_reset");
      chk("after_reset_id", 256'(last_id), 256'(2));
      chk("after_reset_count", 256'(rsp_cnt), 256'(n + 1));
      chk("one_start_per_grant", 256'(starts), 256'(grants));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "global timeout");
   end

endmodule
